// File: rtl/capture_controller_pkg.sv
// Shared opcodes, state encodings and constants for the capture controller.
package capture_controller_pkg;

  localparam logic [7:0] OP_RESET     = 8'h00;
  localparam logic [7:0] OP_RUN       = 8'h01;
  localparam logic [7:0] OP_ID        = 8'h02;
  localparam logic [7:0] OP_META      = 8'h04;
  localparam logic [7:0] OP_DIV       = 8'h80;
  localparam logic [7:0] OP_CNT       = 8'h81;
  localparam logic [7:0] OP_TRIG_RISE = 8'hC0;
  localparam logic [7:0] OP_TRIG_FALL = 8'hC1;
  localparam logic [7:0] OP_TRIG_CFG  = 8'hC2;

  localparam int unsigned WDOG_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READBACK,
    RB_WAIT,
    ID_WAIT,
    META
  } ctrl_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT_HIGH,
    HS_WAIT_LOW
  } hs_state_t;

endpackage

// File: rtl/capture_controller_tx.sv
// UART word handshake: after start, wait for transmit_busy high then low.
// With CAPTURE_CONTROLLER_WATCHDOG_EN, a busy that never rises ends the wait.
module tx_handshake
  import capture_controller_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic transmit_busy,
  output logic done,
  output logic timeout
);

  hs_state_t state, state_next;

`ifdef CAPTURE_CONTROLLER_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wcnt;

  // Counts from the cycle the request pulse is visible.
  always_ff @(posedge clock) begin
    if (reset || start) wcnt <= '0;
    else if (state == HS_WAIT_HIGH) wcnt <= wcnt + WW'(1);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset || abort) state <= HS_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      HS_IDLE: if (start) state_next = HS_WAIT_HIGH;
      HS_WAIT_HIGH: begin
        if (transmit_busy) state_next = HS_WAIT_LOW;
`ifdef CAPTURE_CONTROLLER_WATCHDOG_EN
        else if (wcnt == WDOG_LAST) begin
          timeout    = 1'b1;
          done       = 1'b1;
          state_next = HS_IDLE;
        end
`endif
      end
      HS_WAIT_LOW: begin
        if (!transmit_busy) begin
          done       = 1'b1;
          state_next = HS_IDLE;
        end
      end
      default: state_next = HS_IDLE;
    endcase
  end

endmodule

// File: rtl/capture_controller.sv
// SUMP-style capture controller: config registers and acquisition/readback FSM.
// Optional UART watchdog enabled by CAPTURE_CONTROLLER_WATCHDOG_EN.
module capture_controller
  import capture_controller_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned STAGES       = 4,
  parameter int unsigned DIV_WIDTH    = 24,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [7:0]                     opcode,
  input  logic [31:0]                    command,
  input  logic                           cmd_recv_rx,
  input  logic                           run,
  input  logic                           sample_valid,
  input  logic                           transmit_busy,
  input  logic                           meta_transmit_finish,
  output logic [DIV_WIDTH-1:0]           divider,
  output logic                           arm,
  output logic                           capture_enable,
  output logic                           rd_req,
  output logic                           send_id,
  output logic                           begin_meta_transmit,
  output logic                           data_meta_mux,
  output logic [STAGES*SAMPLE_WIDTH-1:0] rise_patterns,
  output logic [STAGES*SAMPLE_WIDTH-1:0] fall_patterns,
  output logic [STAGES-1:0]              stage_enable,
  output logic                           capture_done,
  output logic                           busy,
  output logic                           tx_error
);

  localparam logic [CNT_WIDTH:0] CNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

  ctrl_state_t state, state_next;

  logic [CNT_WIDTH-1:0] read_cnt, delay_cnt;
  logic [CNT_WIDTH:0]   dcnt, rcnt;

  logic       op_reset, op_idle, trig_op;
  logic [2:0] trig_stage;
  logic [1:0] trig_kind;

  logic load_dcnt, dec_dcnt, load_rcnt, dec_rcnt;
  logic hs_start, hs_done, hs_timeout;
  logic rd_req_next, send_id_next, meta_next, done_next;

  assign op_reset   = cmd_recv_rx && (opcode == OP_RESET);
  assign op_idle    = cmd_recv_rx && (state == IDLE);
  assign trig_op    = op_idle && (opcode[7:5] == OP_TRIG_RISE[7:5]);
  assign trig_stage = opcode[4:2];
  assign trig_kind  = opcode[1:0];

  assign arm            = (state == ARMED) || (state == CAPTURE);
  assign capture_enable = arm;
  assign busy           = (state != IDLE);
  assign data_meta_mux  = (state == META);

  tx_handshake u_tx_handshake (
    .clock         (clock),
    .reset         (reset),
    .start         (hs_start),
    .abort         (op_reset),
    .transmit_busy (transmit_busy),
    .done          (hs_done),
    .timeout       (hs_timeout)
  );

  // Configuration is writable only while idle; stages beyond STAGES are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      divider       <= '0;
      read_cnt      <= '0;
      delay_cnt     <= '0;
      rise_patterns <= '0;
      fall_patterns <= '0;
      stage_enable  <= '0;
    end else if (op_idle) begin
      if (opcode == OP_DIV) divider <= command[DIV_WIDTH-1:0];
      if (opcode == OP_CNT) begin
        read_cnt  <= command[CNT_WIDTH-1:0];
        delay_cnt <= command[16 +: CNT_WIDTH];
      end
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (trig_op && trig_stage == 3'(s)) begin
          case (trig_kind)
            OP_TRIG_RISE[1:0]: rise_patterns[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= command[SAMPLE_WIDTH-1:0];
            OP_TRIG_FALL[1:0]: fall_patterns[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= command[SAMPLE_WIDTH-1:0];
            OP_TRIG_CFG[1:0]:  stage_enable[s] <= command[0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    state_next   = state;
    load_dcnt    = 1'b0;
    dec_dcnt     = 1'b0;
    load_rcnt    = 1'b0;
    dec_rcnt     = 1'b0;
    hs_start     = 1'b0;
    rd_req_next  = 1'b0;
    send_id_next = 1'b0;
    meta_next    = 1'b0;
    done_next    = 1'b0;
    if (op_reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_recv_rx) begin
            case (opcode)
              OP_RUN:  state_next = ARMED;
              OP_ID: begin
                send_id_next = 1'b1;
                hs_start     = 1'b1;
                state_next   = ID_WAIT;
              end
              OP_META: begin
                meta_next  = 1'b1;
                state_next = META;
              end
              default: ;
            endcase
          end
        end
        ARMED: begin
          if (run) begin
            load_dcnt  = 1'b1;
            state_next = CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            if (dcnt == CNT_ONE) begin
              load_rcnt  = 1'b1;
              state_next = READBACK;
            end else begin
              dec_dcnt = 1'b1;
            end
          end
        end
        READBACK: begin
          if (!transmit_busy) begin
            rd_req_next = 1'b1;
            hs_start    = 1'b1;
            state_next  = RB_WAIT;
          end
        end
        RB_WAIT: begin
          if (hs_done) begin
            dec_rcnt = 1'b1;
            if (rcnt == CNT_ONE) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = READBACK;
            end
          end
        end
        ID_WAIT: if (hs_done) state_next = IDLE;
        META:    if (meta_transmit_finish) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pulses are registered so they line up with the state they start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      dcnt                <= '0;
      rcnt                <= '0;
      rd_req              <= 1'b0;
      send_id             <= 1'b0;
      begin_meta_transmit <= 1'b0;
      capture_done        <= 1'b0;
      tx_error            <= 1'b0;
    end else begin
      state               <= state_next;
      rd_req              <= rd_req_next;
      send_id             <= send_id_next;
      begin_meta_transmit <= meta_next;
      capture_done        <= done_next;
      if (load_dcnt)     dcnt <= {1'b0, delay_cnt} + CNT_ONE;
      else if (dec_dcnt) dcnt <= dcnt - CNT_ONE;
      if (load_rcnt)     rcnt <= {1'b0, read_cnt} + CNT_ONE;
      else if (dec_rcnt) rcnt <= rcnt - CNT_ONE;
      if (op_reset)        tx_error <= 1'b0;
      else if (hs_timeout) tx_error <= 1'b1;
    end
  end

endmodule
